// File: rtl/rx_frame_sync_if.sv
// rx_frame_sync_if: signal bundle between the RF demodulator / RX controller
// and the frame synchronizer.
//   rfin      raw demodulator data, asynchronous to clk
//   en        receive enable; low forces the receiver idle
//   bit_out   last recovered bit, qualified by bit_stb
//   bit_stb   one-cycle strobe per recovered bit
//   sync_det  one-cycle pulse on sync word match
//   pkt_dout  last complete payload, first received bit in the MSB
//   pkt_rec   one-cycle pulse, pkt_dout newly updated
//   busy      high while a payload is being collected
//   err       one-cycle pulse on loss-of-signal abort
// slave is the synchronizer side, master the side that drives rfin/en.
interface rx_frame_sync_if #(
   parameter int PACKET_SIZE = 64
);
   logic                   rfin;
   logic                   en;
   logic                   bit_out;
   logic                   bit_stb;
   logic                   sync_det;
   logic [PACKET_SIZE-1:0] pkt_dout;
   logic                   pkt_rec;
   logic                   busy;
   logic                   err;

   modport master (
      output rfin, en,
      input  bit_out, bit_stb, sync_det, pkt_dout, pkt_rec, busy, err
   );

   modport slave (
      input  rfin, en,
      output bit_out, bit_stb, sync_det, pkt_dout, pkt_rec, busy, err
   );
endinterface

// File: rtl/rx_frame_sync.sv
// rx_frame_sync: synchronizes and oversamples the raw rfin line, recovers NRZ
// bits with edge-based phase alignment, hunts for SYNC_WORD and then collects
// one PACKET_SIZE-bit payload, delivered with a one-cycle pkt_rec pulse.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rx_frame_sync_if.slave (rfin/en in, recovered bits/packet out)
// All outputs are registered.
module rx_frame_sync #(
   parameter int                  OSR         = 8,
   parameter int                  SYNC_LEN    = 16,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 16'hD391,
   parameter int                  PACKET_SIZE = 64,
   parameter int                  LOSS_BITS   = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   rx_frame_sync_if.slave bus
);
   localparam int PH_W     = $clog2(OSR);
   localparam int CNT_W    = $clog2(PACKET_SIZE + 1);
   localparam int LOSS_LIM = LOSS_BITS * OSR;
   localparam int LC_W     = $clog2(LOSS_LIM + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, RECEIVE = 2'd2} state_t;
   state_t state, state_nx;

   logic                   s1, s2, s3;
   logic [PH_W-1:0]        ph;
   logic [SYNC_LEN-1:0]    sync_sr;
   logic [PACKET_SIZE-1:0] pay_sr;
   logic [CNT_W-1:0]       bcnt;
   logic [LC_W-1:0]        lc;

   logic                   edge_det, sample, sync_hit, last_bit, loss_trip;
   logic                   sync_nx, rec_nx, err_nx, busy_nx;
   logic [SYNC_LEN-1:0]    sync_shift;
   logic [PACKET_SIZE-1:0] pay_shift;

   logic                   bit_out_q, bit_stb_q, sync_det_q, pkt_rec_q, busy_q, err_q;
   logic [PACKET_SIZE-1:0] pkt_dout_q;

   assign edge_det   = s2 ^ s3;
   // An edge wins over a coinciding sample phase.
   assign sample     = (state != IDLE) && !edge_det && (ph == PH_W'(OSR / 2));
   assign sync_shift = {sync_sr[SYNC_LEN-2:0], s2};
   assign pay_shift  = {pay_sr[PACKET_SIZE-2:0], s2};
   assign sync_hit   = (state == HUNT) && sample && (sync_shift == SYNC_WORD);
   assign last_bit   = (state == RECEIVE) && sample && (bcnt == CNT_W'(PACKET_SIZE - 1));
   // lc counts clocks since the last edge; trip when the next count reaches the limit.
   assign loss_trip  = (state == RECEIVE) && !edge_det && (lc == LC_W'(LOSS_LIM - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next state
   always_comb begin
      state_nx = state;
      if (!bus.en) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    state_nx = HUNT;
            HUNT:    if (sync_hit) state_nx = RECEIVE;
            RECEIVE: if (last_bit || loss_trip) state_nx = HUNT;
            default: state_nx = IDLE;
         endcase
      end
   end

   // output decode; a completed packet takes precedence over a same-cycle loss trip
   always_comb begin
      sync_nx = bus.en && sync_hit;
      rec_nx  = bus.en && last_bit;
      err_nx  = bus.en && loss_trip && !last_bit;
      // covers the entry cycle and the exit cycle of RECEIVE
      busy_nx = (state == RECEIVE) || (state_nx == RECEIVE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         ph         <= '0;
         sync_sr    <= '0;
         pay_sr     <= '0;
         bcnt       <= '0;
         lc         <= '0;
         bit_out_q  <= 1'b0;
         bit_stb_q  <= 1'b0;
         sync_det_q <= 1'b0;
         pkt_rec_q  <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         pkt_dout_q <= '0;
      end else begin
         s1 <= bus.rfin;
         s2 <= s1;
         s3 <= s2;

         // The edge cycle itself counts as phase 0, so the first sample lands
         // OSR/2 clocks after the edge is detected.
         if (state == IDLE)              ph <= '0;
         else if (edge_det)              ph <= PH_W'(1);
         else if (ph == PH_W'(OSR - 1))  ph <= '0;
         else                            ph <= ph + PH_W'(1);

         // Sync history only lives in HUNT, so payload bits are never searched.
         if (state != HUNT)  sync_sr <= '0;
         else if (sample)    sync_sr <= sync_hit ? '0 : sync_shift;

         if (state != RECEIVE) begin
            bcnt <= '0;
            lc   <= '0;
         end else begin
            if (sample) begin
               bcnt   <= bcnt + CNT_W'(1);
               pay_sr <= pay_shift;
            end
            lc <= edge_det ? LC_W'(1) : lc + LC_W'(1);
         end

         bit_stb_q  <= sample;
         if (sample) bit_out_q <= s2;
         sync_det_q <= sync_nx;
         pkt_rec_q  <= rec_nx;
         err_q      <= err_nx;
         busy_q     <= busy_nx;
         if (rec_nx) pkt_dout_q <= pay_shift;
      end
   end

   assign bus.bit_out  = bit_out_q;
   assign bus.bit_stb  = bit_stb_q;
   assign bus.sync_det = sync_det_q;
   assign bus.pkt_rec  = pkt_rec_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;
   assign bus.pkt_dout = pkt_dout_q;
endmodule

// File: tb/tb_rx_frame_sync.sv
// tb_rx_frame_sync: randomized frame-level bench for rx_frame_sync. Frames are
// built from preamble, sync word and payload bit strings; expectations come
// from the frame content and bit/clock arithmetic.
module tb_rx_frame_sync;
   localparam int          OSR = 8;
   localparam int          PS  = 64;
   localparam logic [15:0] SW  = 16'hD391;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   rx_frame_sync_if #(.PACKET_SIZE(PS)) bus ();

   rx_frame_sync #(
      .OSR(OSR), .SYNC_LEN(16), .SYNC_WORD(SW), .PACKET_SIZE(PS), .LOSS_BITS(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // event recorder
   int            n_sync = 0, n_rec = 0, n_err = 0, n_pstb = 0, busy_bad = 0, err_cyc = -1;
   logic          in_pkt = 1'b0;
   logic          chk_busy = 1'b0;
   logic [PS-1:0] rx_bits = '0;
   logic [PS-1:0] rec_q[$];

   always @(negedge clk) begin
      if (bus.sync_det) n_sync <= n_sync + 1;
      if (bus.pkt_rec) begin
         n_rec <= n_rec + 1;
         rec_q.push_back(bus.pkt_dout);
      end
      if (bus.err) begin
         n_err   <= n_err + 1;
         err_cyc <= cyc;
      end
      if (in_pkt && bus.bit_stb) begin
         n_pstb  <= n_pstb + 1;
         rx_bits <= {rx_bits[PS-2:0], bus.bit_out};
      end
      if (chk_busy && (bus.busy !== (in_pkt || bus.sync_det))) busy_bad <= busy_bad + 1;
      if (bus.sync_det) in_pkt <= 1'b1;
      else if (bus.pkt_rec || bus.err || !bus.en || !rst_n) in_pkt <= 1'b0;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // stimulus helpers (no checking)
   bit            jit_odd = 1'b0;
   int            last_edge = 0;
   logic [PS-1:0] exp_dout = '0;

   task automatic drive_bit(input logic b, input bit jit);
      int per;
      if (jit) begin
         per = jit_odd ? 9 : 7;
         jit_odd = ~jit_odd;
      end else begin
         per = OSR;
      end
      if (b !== bus.rfin) last_edge = cyc;
      bus.rfin = b;
      repeat (per) @(negedge clk);
   endtask

   task automatic send_bits(input logic [PS-1:0] v, input int hi, input int lo, input bit jit);
      for (int i = hi; i >= lo; i--) drive_bit(v[i], jit);
   endtask

   // 16 idle zero bits, 8 alternating preamble bits, then the sync word
   task automatic send_head(input logic [15:0] sync, input bit jit);
      logic [PS-1:0] pre;
      logic [PS-1:0] sw;
      pre = 64'hAA;
      sw  = {48'h0, sync};
      bus.rfin = 1'b0;
      repeat (16 * OSR) @(negedge clk);
      send_bits(pre, 7, 0, jit);
      send_bits(sw, 15, 0, jit);
   endtask

   function automatic bit has_sync(input logic [15:0] sync, input logic [PS-1:0] pay);
      logic [106:0] s;
      s = {16'h0000, 8'hAA, sync, pay, {3{pay[0]}}};
      for (int i = 0; i <= 107 - 16; i++) if (s[i +: 16] == SW) return 1'b1;
      return 1'b0;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.rfin = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.pkt_dout !== '0) begin
         n_bad++; $display("FAIL reset_dout: got %h want 0", bus.pkt_dout);
      end
      n_cmp++;
      if ({bus.bit_out, bus.bit_stb, bus.sync_det, bus.pkt_rec, bus.busy, bus.err} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 000000",
                  {bus.bit_out, bus.bit_stb, bus.sync_det, bus.pkt_rec, bus.busy, bus.err});
      end
      rst_n = 1'b1;
      @(negedge clk);
      bus.en = 1'b1;
      repeat (20 * OSR) @(negedge clk);
      n_cmp++;
      if (n_sync !== 0 || bus.busy !== 1'b0) begin
         n_bad++; $display("FAIL idle_line: got sync=%0d busy=%b want 0 0", n_sync, bus.busy);
      end
   endtask

   task automatic test_good_frame(input string tag, input logic [PS-1:0] pay, input bit jit);
      int s0, r0, p0, e0, b0;
      s0 = n_sync; r0 = n_rec; p0 = n_pstb; e0 = n_err; b0 = busy_bad;
      send_head(SW, jit);
      chk_busy = 1'b1;
      send_bits(pay, PS - 1, 0, jit);
      repeat (3 * OSR) @(negedge clk);
      chk_busy = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (n_sync - s0 !== 1) begin
         n_bad++; $display("FAIL %s_sync_cnt: got %0d want 1", tag, n_sync - s0);
      end
      n_cmp++;
      if (n_rec - r0 !== 1) begin
         n_bad++; $display("FAIL %s_rec_cnt: got %0d want 1", tag, n_rec - r0);
      end
      n_cmp++;
      if (n_pstb - p0 !== PS) begin
         n_bad++; $display("FAIL %s_stb_cnt: got %0d want %0d", tag, n_pstb - p0, PS);
      end
      n_cmp++;
      if (n_err !== e0) begin
         n_bad++; $display("FAIL %s_err_cnt: got %0d want 0", tag, n_err - e0);
      end
      n_cmp++;
      if (bus.pkt_dout !== pay) begin
         n_bad++; $display("FAIL %s_dout: got %h want %h", tag, bus.pkt_dout, pay);
      end
      n_cmp++;
      if (rx_bits !== pay) begin
         n_bad++; $display("FAIL %s_bits: got %h want %h", tag, rx_bits, pay);
      end
      n_cmp++;
      if (busy_bad !== b0) begin
         n_bad++; $display("FAIL %s_busy: got %0d bad cycles want 0", tag, busy_bad - b0);
      end
      exp_dout = pay;
   endtask

   task automatic test_bad_sync();
      logic [PS-1:0] pay;
      int s0, r0;
      do pay = {$urandom, $urandom}; while (has_sync(16'hD390, pay));
      s0 = n_sync; r0 = n_rec;
      send_head(16'hD390, 1'b0);
      send_bits(pay, PS - 1, 0, 1'b0);
      repeat (3 * OSR) @(negedge clk);
      n_cmp++;
      if (n_sync !== s0 || n_rec !== r0) begin
         n_bad++; $display("FAIL bad_sync: got sync=%0d rec=%0d want 0 0", n_sync - s0, n_rec - r0);
      end
      n_cmp++;
      if (bus.pkt_dout !== exp_dout) begin
         n_bad++; $display("FAIL bad_sync_dout: got %h want %h", bus.pkt_dout, exp_dout);
      end
   endtask

   task automatic test_loss();
      logic [PS-1:0] pay;
      int e0, r0;
      pay = {$urandom, $urandom};
      pay[PS-20] = ~pay[PS-19];  // payload bit 19 differs from bit 18: last edge is in RECEIVE
      e0 = n_err; r0 = n_rec;
      send_head(SW, 1'b0);
      send_bits(pay, PS - 1, PS - 20, 1'b0);
      for (int i = 0; i < 400 && n_err == e0; i++) @(negedge clk);
      n_cmp++;
      if (n_err - e0 !== 1) begin
         n_bad++; $display("FAIL loss_err_cnt: got %0d want 1", n_err - e0);
      end
      // 2 clocks through the synchronizer plus 128 clocks of silence
      n_cmp++;
      if (err_cyc - last_edge !== 130) begin
         n_bad++; $display("FAIL loss_timing: got %0d want 130", err_cyc - last_edge);
      end
      n_cmp++;
      if (n_rec !== r0 || bus.pkt_dout !== exp_dout) begin
         n_bad++; $display("FAIL loss_no_pkt: got rec=%0d dout=%h want 0 %h", n_rec - r0, bus.pkt_dout, exp_dout);
      end
   endtask

   task automatic test_en_drop();
      logic [PS-1:0] pay;
      int e0, r0;
      pay = {$urandom, $urandom};
      e0 = n_err; r0 = n_rec;
      send_head(SW, 1'b0);
      send_bits(pay, PS - 1, PS - 30, 1'b0);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
         n_bad++; $display("FAIL en_drop_busy_before: got %b want 1", bus.busy);
      end
      bus.en = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_bad++; $display("FAIL en_drop_busy_after: got %b want 0", bus.busy);
      end
      n_cmp++;
      if (n_rec !== r0 || n_err !== e0) begin
         n_bad++; $display("FAIL en_drop_events: got rec=%0d err=%0d want 0 0", n_rec - r0, n_err - e0);
      end
      n_cmp++;
      if (bus.pkt_dout !== exp_dout) begin
         n_bad++; $display("FAIL en_drop_dout: got %h want %h", bus.pkt_dout, exp_dout);
      end
      bus.en = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [PS-1:0] p1, p2, sw;
      int r0, q0;
      p1 = {$urandom, $urandom};
      p2 = {$urandom, $urandom};
      sw = {48'h0, SW};
      r0 = n_rec; q0 = rec_q.size();
      send_head(SW, 1'b0);
      send_bits(p1, PS - 1, 0, 1'b0);
      send_bits(sw, 15, 0, 1'b0);
      send_bits(p2, PS - 1, 0, 1'b0);
      repeat (3 * OSR) @(negedge clk);
      n_cmp++;
      if (n_rec - r0 !== 2) begin
         n_bad++; $display("FAIL b2b_rec_cnt: got %0d want 2", n_rec - r0);
      end
      n_cmp++;
      if (rec_q.size() < q0 + 2 || rec_q[q0] !== p1) begin
         n_bad++; $display("FAIL b2b_first: got %h want %h", (rec_q.size() > q0) ? rec_q[q0] : '0, p1);
      end
      n_cmp++;
      if (rec_q.size() < q0 + 2 || rec_q[q0+1] !== p2) begin
         n_bad++; $display("FAIL b2b_second: got %h want %h", (rec_q.size() > q0 + 1) ? rec_q[q0+1] : '0, p2);
      end
      exp_dout = p2;
   endtask

   task automatic test_reset_mid();
      logic [PS-1:0] pay;
      int r0;
      pay = {$urandom, $urandom};
      send_head(SW, 1'b0);
      send_bits(pay, PS - 1, PS - 10, 1'b0);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
         n_bad++; $display("FAIL rst_mid_busy_before: got %b want 1", bus.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.pkt_dout !== '0) begin
         n_bad++; $display("FAIL rst_mid_dout: got %h want 0", bus.pkt_dout);
      end
      n_cmp++;
      if ({bus.bit_out, bus.bit_stb, bus.sync_det, bus.pkt_rec, bus.busy, bus.err} !== 6'b0) begin
         n_bad++;
         $display("FAIL rst_mid_flags: got %b want 000000",
                  {bus.bit_out, bus.bit_stb, bus.sync_det, bus.pkt_rec, bus.busy, bus.err});
      end
      @(negedge clk);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_dout = '0;
      r0 = n_rec;
      send_bits(pay, PS - 11, 0, 1'b0);
      repeat (3 * OSR) @(negedge clk);
      n_cmp++;
      if (n_rec !== r0 || bus.pkt_dout !== '0) begin
         n_bad++; $display("FAIL rst_mid_no_pkt: got rec=%0d dout=%h want 0 0", n_rec - r0, bus.pkt_dout);
      end
   endtask

   initial begin
      bus.rfin = 1'b0;
      bus.en = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_good_frame("clean", 64'hDEADBEEF_01234567, 1'b0);
      test_good_frame("clean_rand", {$urandom, $urandom}, 1'b0);
      test_good_frame("jitter", 64'hDEADBEEF_01234567, 1'b1);
      test_good_frame("jitter_rand", {$urandom, $urandom}, 1'b1);
      test_bad_sync();
      test_loss();
      test_good_frame("after_loss", {$urandom, $urandom}, 1'b0);
      test_en_drop();
      test_back_to_back();
      test_reset_mid();
      test_good_frame("after_reset", {$urandom, $urandom}, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
